// File: rtl/pocket_video_rx_if.sv
// pocket_video_rx_if: incoming video stream plus the measurement/lock outputs of pocket_video_rx.
interface pocket_video_rx_if #(
    parameter int CNT_W = 12
);
    logic [23:0]      iRGB;
    logic             iHS;
    logic             iVS;
    logic             iDE;
    logic             iERR_CLR;
    logic [23:0]      oRGB;
    logic             oDE;
    logic             oHS;
    logic             oVS;
    logic [CNT_W-1:0] oX;
    logic [CNT_W-1:0] oY;
    logic [CNT_W-1:0] oH_TOTAL;
    logic [CNT_W-1:0] oH_ACTIVE;
    logic [CNT_W-1:0] oV_TOTAL;
    logic [CNT_W-1:0] oV_ACTIVE;
    logic             oLOCKED;
    logic [2:0]       oERR;
    logic [31:0]      oFRAME_SUM;

    modport master (
        output iRGB, iHS, iVS, iDE, iERR_CLR,
        input  oRGB, oDE, oHS, oVS, oX, oY, oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE,
               oLOCKED, oERR, oFRAME_SUM
    );

    modport slave (
        input  iRGB, iHS, iVS, iDE, iERR_CLR,
        output oRGB, oDE, oHS, oVS, oX, oY, oH_TOTAL, oH_ACTIVE, oV_TOTAL, oV_ACTIVE,
               oLOCKED, oERR, oFRAME_SUM
    );
endinterface

// File: rtl/pocket_video_rx.sv
// pocket_video_rx: checks and measures an APF-style video stream, regenerates wide syncs, reports lock.
// Define POCKET_VIDEO_RX_FRAMESUM_EN to build the per-frame pixel checksum on oFRAME_SUM.
module pocket_video_rx #(
    parameter int CNT_W       = 12,
    parameter int HS_WIDTH    = 32,
    parameter int VS_LINES    = 3,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             iPCLK,
    input  logic             iRST_N,
    pocket_video_rx_if.slave vif
);
    localparam int HW = $clog2(HS_WIDTH + 1);
    localparam int VW = $clog2(VS_LINES + 1);
    localparam int MW = $clog2(LOCK_FRAMES + 2);
    localparam int FW = 2 * CNT_W + 1;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t f_inc(input cnt_t v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t          r_state;
    logic [MW-1:0]   r_match;
    logic            r_locked;
    logic [23:0]     r_rgb;
    logic            r_de;
    cnt_t            r_x, r_y;
    cnt_t            r_hcnt, r_xcnt, r_vcnt, r_ycnt;
    cnt_t            r_h_total, r_h_active, r_v_total, r_v_active;
    cnt_t            r_ref, r_p_ht, r_p_ha, r_p_vt, r_p_va;
    logic            r_first, r_line_ok, r_p_ok;
    logic [FW-1:0]   r_fcnt;
    logic            r_hs_o, r_vs_o;
    logic [HW-1:0]   r_hs_left;
    logic [VW-1:0]   r_vs_left;
    logic            r_hs_d, r_vs_d;
    logic [2:0]      r_err;

    cnt_t            w_hlen, w_ht_new, w_ha_new, w_vt_new;
    logic            w_de_fall, w_line_bad, w_frame_ok, w_match, w_sat, w_timeout;
    logic [2*CNT_W-1:0] w_prod;
    logic [FW-1:0]   w_limit;
    logic [2:0]      w_err_set;

    assign w_hlen     = f_inc(r_hcnt);
    assign w_ht_new   = vif.iHS ? w_hlen : r_h_total;
    assign w_ha_new   = (vif.iHS && r_xcnt != '0) ? r_xcnt : r_h_active;
    assign w_vt_new   = vif.iHS ? f_inc(r_vcnt) : r_vcnt;
    assign w_de_fall  = r_de && !vif.iDE;
    // The first line length seen after VS is the reference for the rest of that frame
    assign w_line_bad = vif.iHS && !r_first && w_hlen != r_ref;
    assign w_frame_ok = r_line_ok && !w_line_bad;
    assign w_match    = r_p_ok && w_frame_ok &&
                        {w_ht_new, w_ha_new, w_vt_new, r_ycnt} == {r_p_ht, r_p_ha, r_p_vt, r_p_va};
    assign w_sat      = (&r_hcnt) || (&r_xcnt) || (&r_vcnt) || (&r_ycnt);
    assign w_prod     = {{CNT_W{1'b0}}, r_v_total} * {{CNT_W{1'b0}}, r_h_total};
    assign w_limit    = {w_prod, 1'b0};
    assign w_timeout  = r_fcnt >= w_limit;
    assign w_err_set  = {!vif.iDE && vif.iRGB != '0, vif.iVS && r_vs_d, vif.iHS && r_hs_d};

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rgb      <= '0;
            r_de       <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_hcnt     <= '0;
            r_xcnt     <= '0;
            r_vcnt     <= '0;
            r_ycnt     <= '0;
            r_h_total  <= '0;
            r_h_active <= '0;
            r_v_total  <= '0;
            r_v_active <= '0;
            r_fcnt     <= '0;
        end else begin
            r_rgb      <= vif.iRGB;
            r_de       <= vif.iDE;
            r_x        <= r_xcnt;
            r_y        <= r_ycnt;
            r_hcnt     <= vif.iHS ? '0 : w_hlen;
            r_xcnt     <= vif.iHS ? '0 : vif.iDE ? f_inc(r_xcnt) : r_xcnt;
            r_vcnt     <= vif.iVS ? '0 : w_vt_new;
            r_ycnt     <= vif.iVS ? '0 : w_de_fall ? f_inc(r_ycnt) : r_ycnt;
            r_h_total  <= w_ht_new;
            r_h_active <= w_ha_new;
            r_v_total  <= vif.iVS ? w_vt_new : r_v_total;
            r_v_active <= vif.iVS ? r_ycnt : r_v_active;
            r_fcnt     <= vif.iVS ? '0 : (&r_fcnt) ? r_fcnt : r_fcnt + 1'b1;
        end
    end

    // Per-frame line consistency and the previous frame's snapshot used for matching
    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_first   <= 1'b0;
            r_line_ok <= 1'b0;
            r_ref     <= '0;
            r_p_ok    <= 1'b0;
            r_p_ht    <= '0;
            r_p_ha    <= '0;
            r_p_vt    <= '0;
            r_p_va    <= '0;
        end else begin
            r_first   <= vif.iVS ? 1'b1 : vif.iHS ? 1'b0 : r_first;
            r_ref     <= (vif.iHS && !vif.iVS && r_first) ? w_hlen : r_ref;
            r_line_ok <= vif.iVS ? 1'b1 : w_frame_ok;
            if (vif.iVS) begin
                r_p_ok <= r_state != SEARCH && w_frame_ok;
                r_p_ht <= w_ht_new;
                r_p_ha <= w_ha_new;
                r_p_vt <= w_vt_new;
                r_p_va <= r_ycnt;
            end
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
        end else if (w_sat) begin
            r_state  <= SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
        end else begin
            unique case (r_state)
                SEARCH: if (vif.iVS) begin
                    r_state <= TRACK;
                    r_match <= '0;
                end
                TRACK: if (vif.iVS) begin
                    r_match <= w_match ? r_match + 1'b1 : '0;
                    if (w_match && {{(32-MW){1'b0}}, r_match} + 32'd2 >= 32'(LOCK_FRAMES)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                LOCKED: if (vif.iVS ? !w_match : (w_line_bad || w_timeout)) begin
                    r_state  <= TRACK;
                    r_match  <= '0;
                    r_locked <= 1'b0;
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hs_o    <= 1'b0;
            r_hs_left <= '0;
            r_vs_o    <= 1'b0;
            r_vs_left <= '0;
            r_hs_d    <= 1'b0;
            r_vs_d    <= 1'b0;
            r_err     <= '0;
        end else begin
            if (vif.iHS) begin
                r_hs_o    <= 1'b1;
                r_hs_left <= HW'(HS_WIDTH - 1);
            end else if (r_hs_left != '0) begin
                r_hs_left <= r_hs_left - 1'b1;
            end else begin
                r_hs_o    <= 1'b0;
            end
            if (vif.iVS) begin
                r_vs_o    <= 1'b1;
                r_vs_left <= VW'(VS_LINES);
            end else if (r_vs_o && vif.iHS) begin
                r_vs_left <= r_vs_left - 1'b1;
                r_vs_o    <= r_vs_left != VW'(1);
            end
            r_hs_d <= vif.iHS;
            r_vs_d <= vif.iVS;
            r_err  <= (vif.iERR_CLR ? 3'b000 : r_err) | w_err_set;
        end
    end

`ifdef POCKET_VIDEO_RX_FRAMESUM_EN
    logic [31:0] r_acc, r_sum;
    logic [31:0] w_add;

    assign w_add = vif.iDE ? {8'h0, vif.iRGB} : 32'h0;

    always_ff @(posedge iPCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_acc <= '0;
            r_sum <= '0;
        end else if (vif.iVS) begin
            r_sum <= r_acc + w_add;
            r_acc <= '0;
        end else begin
            r_acc <= r_acc + w_add;
        end
    end

    assign vif.oFRAME_SUM = r_sum;
`else
    assign vif.oFRAME_SUM = 32'h0;
`endif

    assign vif.oRGB      = r_rgb;
    assign vif.oDE       = r_de;
    assign vif.oHS       = r_hs_o;
    assign vif.oVS       = r_vs_o;
    assign vif.oX        = r_x;
    assign vif.oY        = r_y;
    assign vif.oH_TOTAL  = r_h_total;
    assign vif.oH_ACTIVE = r_h_active;
    assign vif.oV_TOTAL  = r_v_total;
    assign vif.oV_ACTIVE = r_v_active;
    assign vif.oLOCKED   = r_locked;
    assign vif.oERR      = r_err;
endmodule
